dca_matrix_lsu_txn_gen: RTL

//  Upstream stage of the DCA matrix LSU request issuer. Accepts one matrix LSU instruction,

---
 rtl/dca_matrix_lsu_txn_gen_pkg.sv | 46 ++++
 rtl/dca_matrix_lsu_txn_gen_if.sv | 24 ++
 rtl/dca_matrix_burst_calc.sv | 33 +++
 rtl/dca_matrix_lsu_txn_gen.sv | 119 +++++++++++
 4 files changed

// File: rtl/dca_matrix_lsu_txn_gen_pkg.sv
// Shared types and widths for the DCA matrix LSU descriptor generator.
// Exports: AXI/matrix widths, lsu_op_e, lsu_inst_t, txn_info_t, to_bitaddr().
package dca_matrix_lsu_txn_gen_pkg;

    localparam int BW_AXI_ADDR = 32;
    localparam int BW_AXI_DATA = 32;
    localparam int BW_AXI_ALEN = 8;
    localparam int BW_BITADDR  = BW_AXI_ADDR + 3;
    localparam int BW_DIM      = 8;
    localparam int BW_REM      = BW_DIM + 1;
    localparam int BW_LSA      = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_FILL  = 2'd3
    } lsu_op_e;

    typedef struct packed {
        logic [BW_LSA-1:0]      addr_lsa_p3;
        logic                   is_float;
        logic                   is_signed;
        logic [BW_DIM-1:0]      num_col_m1;
        logic [BW_DIM-1:0]      num_row_m1;
        logic [BW_AXI_ADDR-1:0] stride_ls3;
        logic [BW_AXI_ADDR-1:0] addr;
        lsu_op_e                opcode;
    } lsu_inst_t;

    typedef struct packed {
        logic                   last_of_matrix;
        logic                   last_of_row;
        logic [BW_AXI_ALEN-1:0] alen;
        logic [BW_BITADDR-1:0]  bitaddr;
    } txn_info_t;

    localparam int BW_TXN_INFO = $bits(txn_info_t);

    function automatic logic [BW_BITADDR-1:0] to_bitaddr(
        input logic [BW_AXI_ADDR-1:0] a
    );
        return {a, 3'b000};
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_txn_gen_if.sv
// Instruction-in / descriptor-out handshake bundle of the LSU descriptor generator.
// slave: the generator; master: instruction source plus descriptor consumer.
interface dca_matrix_lsu_txn_gen_if;
    import dca_matrix_lsu_txn_gen_pkg::*;

    logic      inst_valid;
    logic      inst_ready;
    lsu_inst_t inst;
    logic      txn_valid;
    logic      txn_ready;
    txn_info_t txn_info;
    logic      busy;

    modport master (
        output inst_valid, inst, txn_ready,
        input  inst_ready, txn_valid, txn_info, busy
    );

    modport slave (
        input  inst_valid, inst, txn_ready,
        output inst_ready, txn_valid, txn_info, busy
    );

endinterface

// File: rtl/dca_matrix_burst_calc.sv
// Combinational burst sizer: (cur_addr, rem) -> beats, alen, row_end.
// Limits a burst by remaining row beats, MAX_BURST_LEN and the next boundary.
module dca_matrix_burst_calc
    import dca_matrix_lsu_txn_gen_pkg::*;
#(
    parameter int BEAT_BYTES     = 4,
    parameter int MAX_BURST_LEN  = 16,
    parameter int BOUNDARY_BYTES = 4096
) (
    input  logic [BW_AXI_ADDR-1:0] cur_addr,
    input  logic [BW_REM-1:0]      rem,
    output logic [BW_REM-1:0]      beats,
    output logic [BW_AXI_ALEN-1:0] alen,
    output logic                   row_end
);

    logic [31:0] room;
    logic [31:0] lim;

    always_comb begin
        // beats left before the address crosses the next boundary
        room = 32'(BOUNDARY_BYTES)
             - (32'(cur_addr) % 32'(BOUNDARY_BYTES));
        room = room / 32'(BEAT_BYTES);
        lim  = (32'(rem) < 32'(MAX_BURST_LEN))
             ? 32'(rem) : 32'(MAX_BURST_LEN);
        lim  = (room < lim) ? room : lim;
        beats   = BW_REM'(lim);
        alen    = BW_AXI_ALEN'(lim - 32'd1);
        row_end = (beats == rem);
    end

endmodule

// File: rtl/dca_matrix_lsu_txn_gen.sv
// Walks a matrix LSU instruction row by row, one AXI burst descriptor per handshake.
// Ports: clk, rst (sync, active-high), bus (slave: inst in, txn_info out, busy).
module dca_matrix_lsu_txn_gen
    import dca_matrix_lsu_txn_gen_pkg::*;
#(
    parameter int BW_ELEMENT     = 32,
    parameter int MAX_BURST_LEN  = 16,
    parameter int BOUNDARY_BYTES = 4096
) (
    input logic                     clk,
    input logic                     rst,
    dca_matrix_lsu_txn_gen_if.slave bus
);

    localparam int BEAT_BYTES = BW_AXI_DATA / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int EPB_LOG2   = $clog2(BW_AXI_DATA / BW_ELEMENT);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                 state, state_nx;
    logic [BW_DIM-1:0]      num_row_m1, num_col_m1, row;
    logic [BW_AXI_ADDR-1:0] stride, row_base, cur_addr, step;
    logic [BW_REM-1:0]      rem, beats;
    logic [BW_AXI_ALEN-1:0] alen;
    logic                   row_end, last_row;
    logic                   launch, fire;
    logic                   unused_inst;

    // elements per beat is a power of two, so the ceil is a shift plus one
    function automatic logic [BW_REM-1:0] row_beats(
        input logic [BW_DIM-1:0] col_m1
    );
        return (BW_REM'(col_m1) >> EPB_LOG2) + BW_REM'(1);
    endfunction

    assign unused_inst = ^{bus.inst.addr_lsa_p3,
                           bus.inst.is_float,
                           bus.inst.is_signed};

    assign launch = bus.inst_valid && (state == S_IDLE)
                 && (bus.inst.opcode == OP_READ
                  || bus.inst.opcode == OP_WRITE);
    assign fire     = bus.txn_valid && bus.txn_ready;
    assign last_row = (row == num_row_m1);
    assign step     = BW_AXI_ADDR'(beats) << BEAT_SHIFT;

    dca_matrix_burst_calc #(
        .BEAT_BYTES     (BEAT_BYTES),
        .MAX_BURST_LEN  (MAX_BURST_LEN),
        .BOUNDARY_BYTES (BOUNDARY_BYTES)
    ) u_calc (
        .cur_addr (cur_addr),
        .rem      (rem),
        .beats    (beats),
        .alen     (alen),
        .row_end  (row_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.inst_ready = (state == S_IDLE);
        bus.busy       = (state == S_RUN);
        bus.txn_valid  = (state == S_RUN);
        bus.txn_info   = '0;
        unique case (state)
            S_IDLE: begin
                if (launch) state_nx = S_RUN;
            end
            S_RUN: begin
                bus.txn_info.last_of_matrix = row_end && last_row;
                bus.txn_info.last_of_row    = row_end;
                bus.txn_info.alen           = alen;
                bus.txn_info.bitaddr        = to_bitaddr(cur_addr);
                if (fire && row_end && last_row) state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_row_m1 <= '0;
            num_col_m1 <= '0;
            stride     <= '0;
            row        <= '0;
            row_base   <= '0;
            cur_addr   <= '0;
            rem        <= '0;
        end else if (launch) begin
            num_row_m1 <= bus.inst.num_row_m1;
            num_col_m1 <= bus.inst.num_col_m1;
            stride     <= bus.inst.stride_ls3;
            row        <= '0;
            row_base   <= bus.inst.addr;
            cur_addr   <= bus.inst.addr;
            rem        <= row_beats(bus.inst.num_col_m1);
        end else if (fire) begin
            if (!row_end) begin
                cur_addr <= cur_addr + step;
                rem      <= rem - beats;
            end else if (!last_row) begin
                row      <= row + 1'b1;
                row_base <= row_base + stride;
                cur_addr <= row_base + stride;
                rem      <= row_beats(num_col_m1);
            end
        end
    end

    a_align: assert property (@(posedge clk) disable iff (rst)
        launch |-> ((32'(bus.inst.addr) % 32'(BEAT_BYTES)) == 0
                 && (32'(bus.inst.stride_ls3) % 32'(BEAT_BYTES)) == 0));

endmodule
